ws_pe_array: RTL and testbench
==============================

# ws_pe_array

Weight-stationary systolic matrix-multiply array of ROWS x COLS multiply-accumulate processing elements (PEs). Weights are shifted in column-wise from the top and held stationary. Input activations (iacts) stream left-to-right along rows. Partial sums (psums) flow top-to-bottom and exit at the bottom of each column. It is the compute core of the accelerator datapath; input skewing and output de-skewing are done by the surrounding logic.

## Interface
- ROWS, default 3: number of PE rows (number of iact lanes, reduction depth).
- COLS, default 3: number of PE columns (number of weight lanes and psum outputs).
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- iacts  input  [0:ROWS-1][31:0]  one activation per row; iacts[r] feeds PE(r,0).
- weights  input  [0:COLS-1][15:0]  one weight per column; weights[c] feeds PE(0,c) during load.
- load_weight  input  1  weight shift enable.
- psums  output  [0:COLS-1][47:0]  psums[c] = psum register of PE(ROWS-1,c).

## Operation
- Each PE(r,c) holds three registers: weight_reg (16 b), iact_reg (32 b), psum_reg (48 b).
- Weight load, when load_weight=1 at an edge:
  - weight_reg(0,c) <= weights[c].
  - weight_reg(r,c) <= weight_reg(r-1,c) for r>0.
- When load_weight=0, weight_reg holds its value.
- After ROWS consecutive load cycles, the vector presented first sits in row ROWS-1 and the vector presented last sits in row 0. Callers present rows bottom-first.
- Iact path, every edge:
  - iact_reg(r,c) <= iact_in(r,c).
  - iact_in(r,0) = iacts[r]; iact_in(r,c) = iact_reg(r,c-1) for c>0.
- Psum path, every edge:
  - psum_reg(r,c) <= psum_in(r,c) + iact_in(r,c) * weight_reg(r,c).
  - psum_in(0,c) = 0; psum_in(r,c) = psum_reg(r-1,c) for r>0.
- The MAC runs every cycle regardless of load_weight. Results computed during a load use the weights present before that edge.
- Arithmetic: unsigned. The 32x16 product is 48 b. The sum wraps modulo 2^48 with no saturation and no overflow flag.
- Callers must skew iacts so that row r receives element r of a vector r cycles after row 0.

## Timing
- Reset: all weight_reg, iact_reg and psum_reg cleared to 0, so psums = 0 the cycle after rst. rst has priority over load_weight.
- Reset asserted mid-stream discards all in-flight data and loaded weights; weights must be reloaded.
- Weight load takes ROWS cycles.
- Iact hop latency: 1 cycle per column.
- For a skewed vector whose row-0 element is sampled at edge k, psums[c] holds the full dot product sum_r x[r]*W(r,c) after edge k+ROWS+c-1, i.e. valid during cycle k+ROWS+c.
- Throughput: one vector per cycle. Outputs are column-skewed by one cycle per column.
- No handshake and no valid signals; all inputs are sampled every cycle.

## Configuration
- PE_ARRAY_SIGNED_EN defined: iacts, weights and psums are two's complement. Products are sign-extended to 48 b, with wrap-around accumulation modulo 2^48.
- PE_ARRAY_SIGNED_EN undefined (default): all arithmetic unsigned as above.

## Test plan
- Reset: drive random inputs with rst=1 for 2 cycles -> psums = {0,0,0}; internal weights all 0.
- Load and compute (3x3):
  - Load {7,8,9}, then {4,5,6}, then {1,2,3}, giving row r weights 3r+1..3r+3.
  - Feed skewed x = {1,2,3}: row0 = 1 at cycle k, row1 = 2 at k+1, row2 = 3 at k+2, zeros otherwise.
  - Response: psums[0] = 30 at k+3, psums[1] = 36 at k+4, psums[2] = 42 at k+5.
- Weight hold: after the load above, toggle weights with load_weight=0, then repeat x = {1,2,3} -> identical results 30/36/42.
- Streaming: feed x = {1,2,3}, then x = {3,2,1} one cycle later, both skewed.
  - First vector: 30/36/42.
  - Second vector, each result one cycle after the first: 3+8+7 = 18, 6+10+8 = 24, 9+12+9 = 30.
- Wrap: all weights 0xFFFF; iacts 0xFFFFFFFF on all rows, skewed -> each psums[c] = 0xFFFCFFFD0003 (3 x 0xFFFEFFFF0001 mod 2^48).
- Reset mid-stream: assert rst during streaming -> psums = 0 next cycle. With no weight reload, later vectors produce 0.

Source files
------------

// File: rtl/ws_pe_array_if.sv
// Bus bundle for ws_pe_array: iact lanes, weight lanes, load strobe, psum outputs
// and the east-edge iact taps of the last column.
interface ws_pe_array_if #(
  parameter int ROWS = 3,
  parameter int COLS = 3
);
  // No handshake: every signal is sampled or updated on every rising edge; callers own skewing.
  logic [0:ROWS-1][31:0] iacts;
  logic [0:COLS-1][15:0] weights;
  logic                  load_weight;
  logic [0:COLS-1][47:0] psums;
  logic [0:ROWS-1][31:0] iact_east;

  modport master (
    output iacts, weights, load_weight,
    input  psums, iact_east
  );

  modport slave (
    input  iacts, weights, load_weight,
    output psums, iact_east
  );
endinterface

// File: rtl/ws_pe_array.sv
// Weight-stationary ROWS x COLS systolic MAC array: weights shift down, iacts flow east,
// psums flow south. Define PE_ARRAY_SIGNED_EN for two's-complement arithmetic.
module ws_pe_array #(
  parameter int ROWS = 3,
  parameter int COLS = 3
) (
  input  logic          clk,
  input  logic          rst,
  ws_pe_array_if.slave  bus
);

  logic [15:0] r_weight  [ROWS][COLS];
  logic [31:0] r_iact    [ROWS][COLS];
  logic [47:0] r_psum    [ROWS][COLS];
  logic [31:0] w_iact_in [ROWS][COLS];
  logic [47:0] w_psum_in [ROWS][COLS];
  logic [47:0] w_prod    [ROWS][COLS];

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      logic [47:0] w_a;
      logic [47:0] w_b;

      if (c == 0) begin : g_west
        assign w_iact_in[r][c] = bus.iacts[r];
      end else begin : g_inner_w
        assign w_iact_in[r][c] = r_iact[r][c-1];
      end

      if (r == 0) begin : g_north
        assign w_psum_in[r][c] = 48'd0;
      end else begin : g_inner_n
        assign w_psum_in[r][c] = r_psum[r-1][c];
      end

      // Operands widened to 48 b so the truncated product is exact modulo 2^48.
`ifdef PE_ARRAY_SIGNED_EN
      assign w_a = {{16{w_iact_in[r][c][31]}}, w_iact_in[r][c]};
      assign w_b = {{32{r_weight[r][c][15]}}, r_weight[r][c]};
`else
      assign w_a = {16'd0, w_iact_in[r][c]};
      assign w_b = {32'd0, r_weight[r][c]};
`endif
      assign w_prod[r][c] = w_a * w_b;
    end
  end

  for (genvar c = 0; c < COLS; c++) begin : g_out
    assign bus.psums[c] = r_psum[ROWS-1][c];
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_east
    assign bus.iact_east[r] = r_iact[r][COLS-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          r_weight[r][c] <= 16'd0;
          r_iact[r][c]   <= 32'd0;
          r_psum[r][c]   <= 48'd0;
        end
      end
    end else begin
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          r_iact[r][c] <= w_iact_in[r][c];
          r_psum[r][c] <= w_psum_in[r][c] + w_prod[r][c];
        end
      end
      if (bus.load_weight) begin
        for (int c = 0; c < COLS; c++) begin
          r_weight[0][c] <= bus.weights[c];
        end
        for (int r = 1; r < ROWS; r++) begin
          for (int c = 0; c < COLS; c++) begin
            r_weight[r][c] <= r_weight[r-1][c];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ws_pe_array.sv
// Scoreboard bench for ws_pe_array (3x3, unsigned build): directed vectors with
// hand-computed psums queued by cycle and checked by a negedge monitor.
module tb_ws_pe_array;
  localparam int ROWS = 3;
  localparam int COLS = 3;

  logic clk;
  logic rst;
  int   cyc;
  int   checks;
  int   errors;
  bit   done;
  bit   reported;

  // Entry: [87] kind (0 psum, 1 weight-zero), [86:56] cycle, [55:48] column, [47:0] value
  logic [87:0] exp_q[$];

  logic [31:0] vx [0:1][0:ROWS-1];
  logic [47:0] ve [0:1][0:COLS-1];

  ws_pe_array_if #(.ROWS(ROWS), .COLS(COLS)) bus ();

  ws_pe_array #(.ROWS(ROWS), .COLS(COLS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Clock / cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare every queued expectation that falls due this cycle
  always @(negedge clk) begin
    for (int i = exp_q.size() - 1; i >= 0; i--) begin
      if (exp_q[i][86:56] == 31'(cyc)) begin
        if (exp_q[i][87]) begin
          for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
              checks++;
              if (dut.r_weight[r][c] !== 16'd0) begin
                errors++;
                $display("FAIL weight_reset r%0d c%0d cyc %0d: got %0h want 0",
                         r, c, cyc, dut.r_weight[r][c]);
              end
            end
          end
        end else begin
          checks++;
          if (bus.psums[exp_q[i][55:48]] !== exp_q[i][47:0]) begin
            errors++;
            $display("FAIL psum c%0d cyc %0d: got %0h want %0h", exp_q[i][55:48], cyc,
                     bus.psums[exp_q[i][55:48]], exp_q[i][47:0]);
          end
        end
        exp_q.delete(i);
      end
    end
    if (done && !reported) begin
      reported = 1'b1;
      checks++;
      if (exp_q.size() != 0) begin
        errors++;
        $display("FAIL leftover_expectations: got %0d pending want 0", exp_q.size());
      end
    end
  end

  // Driver tasks
  task automatic push(input int at, input int col, input logic [47:0] v, input bit kind);
    exp_q.push_back({kind, 31'(at), 8'(col), v});
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load_row(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
    bus.weights     = {a, b, c};
    bus.load_weight = 1'b1;
    @(posedge clk);
    #1;
    bus.load_weight = 1'b0;
  endtask

  // Skewed feed of nv consecutive vectors from vx; queues ve results when chk is set.
  task automatic feed(input int nv, input bit chk);
    int n;
    n = cyc;
    if (chk) begin
      for (int v = 0; v < nv; v++)
        for (int c = 0; c < COLS; c++)
          push(n + v + ROWS + c, c, ve[v][c], 1'b0);
    end
    for (int t = 0; t < nv + ROWS - 1; t++) begin
      if (t > 0) begin
        @(posedge clk);
        #1;
      end
      for (int r = 0; r < ROWS; r++) begin
        bus.iacts[r] = 32'd0;
        if (t - r >= 0 && t - r < nv) bus.iacts[r] = vx[t-r][r];
      end
    end
    @(posedge clk);
    #1;
    bus.iacts = '0;
  endtask

  task automatic set_vec(input int v, input logic [31:0] x0, input logic [31:0] x1,
                         input logic [31:0] x2, input logic [47:0] e0, input logic [47:0] e1,
                         input logic [47:0] e2);
    vx[v][0] = x0; vx[v][1] = x1; vx[v][2] = x2;
    ve[v][0] = e0; ve[v][1] = e1; ve[v][2] = e2;
  endtask

  initial begin
    int n;
    checks = 0;
    errors = 0;
    done = 1'b0;
    reported = 1'b0;

    // Reset with random inputs for two cycles
    rst = 1'b1;
    for (int r = 0; r < ROWS; r++) bus.iacts[r] = $urandom;
    for (int c = 0; c < COLS; c++) bus.weights[c] = 16'($urandom_range(0, 65535));
    bus.load_weight = 1'($urandom_range(0, 1));
    for (int c = 0; c < COLS; c++) begin
      push(1, c, 48'd0, 1'b0);
      push(2, c, 48'd0, 1'b0);
    end
    push(2, 0, 48'd0, 1'b1);
    idle(2);
    rst = 1'b0;
    bus.iacts = '0;
    bus.weights = '0;
    bus.load_weight = 1'b0;
    idle(1);

    // Load rows bottom-first, then compute x = {1,2,3}
    load_row(16'd7, 16'd8, 16'd9);
    load_row(16'd4, 16'd5, 16'd6);
    load_row(16'd1, 16'd2, 16'd3);
    set_vec(0, 1, 2, 3, 48'd30, 48'd36, 48'd42);
    feed(1, 1'b1);
    idle(6);

    // Weight hold: wiggle weights with load disabled
    bus.weights = {16'hABCD, 16'h1234, 16'hFFFF};
    feed(1, 1'b1);
    idle(6);

    // Streaming two vectors back to back
    set_vec(0, 1, 2, 3, 48'd30, 48'd36, 48'd42);
    set_vec(1, 3, 2, 1, 48'd18, 48'd24, 48'd30);
    feed(2, 1'b1);
    idle(6);

    // Wrap-around modulo 2^48
    load_row(16'hFFFF, 16'hFFFF, 16'hFFFF);
    load_row(16'hFFFF, 16'hFFFF, 16'hFFFF);
    load_row(16'hFFFF, 16'hFFFF, 16'hFFFF);
    set_vec(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
            48'hFFFC_FFFD_0003, 48'hFFFC_FFFD_0003, 48'hFFFC_FFFD_0003);
    feed(1, 1'b1);
    idle(6);

    // Reset mid-stream: reload 1..9 weights, stream, hit reset two cycles in
    load_row(16'd7, 16'd8, 16'd9);
    load_row(16'd4, 16'd5, 16'd6);
    load_row(16'd1, 16'd2, 16'd3);
    set_vec(0, 1, 2, 3, 48'd30, 48'd36, 48'd42);
    n = cyc;
    for (int t = 3; t <= 7; t++)
      for (int c = 0; c < COLS; c++) push(n + t, c, 48'd0, 1'b0);
    push(n + 3, 0, 48'd0, 1'b1);
    fork
      feed(1, 1'b0);
      begin
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
      end
    join
    idle(6);

    // No reload after reset: weights are zero, results are zero
    set_vec(0, 1, 2, 3, 48'd0, 48'd0, 48'd0);
    feed(1, 1'b1);
    idle(6);

    done = 1'b1;
    idle(3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
